// File: rtl/bus_round_robin_arbiter_if.sv
// Shared-bus arbitration interface: per-device requests and payloads in,
// registered one-hot grant and muxed owner payload out.
interface bus_round_robin_arbiter_if #(
   parameter int unsigned NUM_DEVICES = 8,
   parameter int unsigned ID_WIDTH    = 3,
   parameter int unsigned D_WIDTH     = 32,
   parameter int unsigned C_WIDTH     = 8
);
   logic [NUM_DEVICES-1:0]         req;
   logic [NUM_DEVICES-1:0]         ack;
   logic [NUM_DEVICES*D_WIDTH-1:0] bus_in;
   logic [NUM_DEVICES*C_WIDTH-1:0] ctrl_in;
   logic [D_WIDTH-1:0]             bus_out;
   logic [C_WIDTH-1:0]             ctrl_out;
   logic                           busy;
   logic [ID_WIDTH-1:0]            owner_id;
   logic                           timeout_err;

   // Requester side
   modport master (
      output req, bus_in, ctrl_in,
      input  ack, bus_out, ctrl_out, busy, owner_id, timeout_err
   );

   // Arbiter side
   modport slave (
      input  req, bus_in, ctrl_in,
      output ack, bus_out, ctrl_out, busy, owner_id, timeout_err
   );
endinterface

// File: rtl/bus_round_robin_arbiter.sv
// Round-robin bus arbiter with registered grants, hold-time watchdog and
// an owner-selected data/control drive that reads zero while idle.
module bus_round_robin_arbiter #(
   parameter int unsigned NUM_DEVICES = 8,
   parameter int unsigned ID_WIDTH    = 3,
   parameter int unsigned D_WIDTH     = 32,
   parameter int unsigned C_WIDTH     = 8,
   parameter int unsigned MAX_HOLD    = 255
) (
   input logic                       clk50MHz,
   input logic                       reset,
   bus_round_robin_arbiter_if.slave  bus
);
   localparam int unsigned CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
   localparam bit WD_EN = (MAX_HOLD != 0);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] OWNED = 1'b1;

   logic [0:0]             state, state_nxt;
   logic [NUM_DEVICES-1:0] ack_q, ack_nxt;
   logic [NUM_DEVICES-1:0] mask, mask_nxt;
   logic [ID_WIDTH-1:0]    owner_q, owner_nxt;
   logic [ID_WIDTH-1:0]    last_owner, last_owner_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   busy_q, busy_nxt;
   logic                   tmo_q, tmo_nxt;

   logic [NUM_DEVICES-1:0] cand;
   logic [ID_WIDTH-1:0]    winner;
   logic                   found;
   logic                   owner_req;
   logic [D_WIDTH-1:0]     data_mux;
   logic [C_WIDTH-1:0]     ctrl_mux;

   assign owner_req = bus.req[owner_q];

   // First eligible requester scanning upward from the slot after the last owner
   always_comb begin
      cand   = bus.req & ~mask;
      winner = '0;
      found  = 1'b0;
      for (int unsigned k = 1; k <= NUM_DEVICES; k++) begin
         if (!found && cand[ID_WIDTH'(last_owner + ID_WIDTH'(k))]) begin
            found  = 1'b1;
            winner = ID_WIDTH'(last_owner + ID_WIDTH'(k));
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nxt      = state;
      ack_nxt        = ack_q;
      owner_nxt      = owner_q;
      last_owner_nxt = last_owner;
      cnt_nxt        = cnt;
      busy_nxt       = busy_q;
      tmo_nxt        = 1'b0;
      mask_nxt       = mask & bus.req;

      case (state)
         IDLE: begin
            if (found) begin
               state_nxt      = OWNED;
               ack_nxt        = NUM_DEVICES'(1) << winner;
               owner_nxt      = winner;
               last_owner_nxt = winner;
               cnt_nxt        = '0;
               busy_nxt       = 1'b1;
            end
         end
         OWNED: begin
            if (!owner_req) begin
               state_nxt = IDLE;
               ack_nxt   = '0;
               owner_nxt = '0;
               busy_nxt  = 1'b0;
               cnt_nxt   = '0;
            end else if (WD_EN && (cnt == CNT_LAST)) begin
               // Revoked owner stays masked until it drops its request
               state_nxt = IDLE;
               ack_nxt   = '0;
               owner_nxt = '0;
               busy_nxt  = 1'b0;
               cnt_nxt   = '0;
               tmo_nxt   = 1'b1;
               mask_nxt  = mask_nxt | (NUM_DEVICES'(1) << owner_q);
            end else if (cnt != CNT_SAT) begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            ack_nxt   = '0;
            owner_nxt = '0;
            busy_nxt  = 1'b0;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk50MHz) begin
      if (reset) begin
         state      <= IDLE;
         ack_q      <= '0;
         mask       <= '0;
         owner_q    <= '0;
         last_owner <= ID_WIDTH'(NUM_DEVICES - 1);
         cnt        <= '0;
         busy_q     <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         ack_q      <= ack_nxt;
         mask       <= mask_nxt;
         owner_q    <= owner_nxt;
         last_owner <= last_owner_nxt;
         cnt        <= cnt_nxt;
         busy_q     <= busy_nxt;
         tmo_q      <= tmo_nxt;
      end
   end

   // AND-OR select on the one-hot grant; yields zero with no owner
   always_comb begin
      data_mux = '0;
      ctrl_mux = '0;
      for (int unsigned i = 0; i < NUM_DEVICES; i++) begin
         if (ack_q[i]) begin
            data_mux = data_mux | bus.bus_in[i*D_WIDTH +: D_WIDTH];
            ctrl_mux = ctrl_mux | bus.ctrl_in[i*C_WIDTH +: C_WIDTH];
         end
      end
   end

   assign bus.ack         = ack_q;
   assign bus.busy        = busy_q;
   assign bus.owner_id    = owner_q;
   assign bus.timeout_err = tmo_q;
   assign bus.bus_out     = data_mux;
   assign bus.ctrl_out    = ctrl_mux;

endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// Directed bench for the round-robin bus arbiter (watchdog set to 4 cycles).
module tb_bus_round_robin_arbiter;
   localparam int unsigned N    = 8;
   localparam int unsigned IDW  = 3;
   localparam int unsigned DW   = 32;
   localparam int unsigned CW   = 8;
   localparam int unsigned HOLD = 4;

   logic clk = 1'b0;
   logic reset;
   logic run_checks = 1'b0;
   int   total  = 0;
   int   passed = 0;

   always #10 clk = ~clk;

   bus_round_robin_arbiter_if #(.NUM_DEVICES(N), .ID_WIDTH(IDW), .D_WIDTH(DW), .C_WIDTH(CW)) bif ();

   bus_round_robin_arbiter #(
      .NUM_DEVICES(N), .ID_WIDTH(IDW), .D_WIDTH(DW), .C_WIDTH(CW), .MAX_HOLD(HOLD)
   ) dut (
      .clk50MHz (clk),
      .reset    (reset),
      .bus      (bif.slave)
   );

   function automatic logic [DW-1:0] exp_data(int i);
      return 32'hD000_0000 | (32'(i) * 32'h111);
   endfunction

   function automatic logic [CW-1:0] exp_ctrl(int i);
      return 8'hC0 | 8'(i);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Grant must be one-hot or zero on every cycle
   always @(negedge clk) begin
      if (run_checks) begin
         total++;
         assert ($onehot0(bif.ack)) passed++;
         else $display("FAIL onehot_ack: got %h want one-hot-or-zero", bif.ack);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic test_reset();
      reset   = 1'b1;
      bif.req = '0;
      tick();
      tick();
      run_checks = 1'b1;
      total++; if (bif.ack !== 8'h00) $display("FAIL reset_ack: got %h want 00", bif.ack); else passed++;
      total++; if (bif.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bif.busy); else passed++;
      total++; if (bif.owner_id !== 3'd0) $display("FAIL reset_owner: got %0d want 0", bif.owner_id); else passed++;
      total++; if (bif.timeout_err !== 1'b0) $display("FAIL reset_tmo: got %b want 0", bif.timeout_err); else passed++;
      total++; if (bif.bus_out !== 32'h0) $display("FAIL reset_bus: got %h want 0", bif.bus_out); else passed++;
      total++; if (bif.ctrl_out !== 8'h0) $display("FAIL reset_ctrl: got %h want 0", bif.ctrl_out); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_single_cpu();
      bif.req = 8'h80;
      tick();
      total++; if (bif.ack !== 8'h80) $display("FAIL cpu_ack: got %h want 80", bif.ack); else passed++;
      total++; if (bif.busy !== 1'b1) $display("FAIL cpu_busy: got %b want 1", bif.busy); else passed++;
      total++; if (bif.owner_id !== 3'd7) $display("FAIL cpu_owner: got %0d want 7", bif.owner_id); else passed++;
      total++; if (bif.bus_out !== exp_data(7)) $display("FAIL cpu_bus: got %h want %h", bif.bus_out, exp_data(7)); else passed++;
      total++; if (bif.ctrl_out !== exp_ctrl(7)) $display("FAIL cpu_ctrl: got %h want %h", bif.ctrl_out, exp_ctrl(7)); else passed++;
      tick();
      bif.req = 8'h00;
      tick();
      total++; if (bif.ack !== 8'h00) $display("FAIL cpu_rel_ack: got %h want 00", bif.ack); else passed++;
      total++; if (bif.busy !== 1'b0) $display("FAIL cpu_rel_busy: got %b want 0", bif.busy); else passed++;
      total++; if (bif.owner_id !== 3'd0) $display("FAIL cpu_rel_owner: got %0d want 0", bif.owner_id); else passed++;
      total++; if (bif.bus_out !== 32'h0) $display("FAIL cpu_rel_bus: got %h want 0", bif.bus_out); else passed++;
   endtask

   task automatic test_alternate();
      logic [7:0] e;
      bif.req = 8'h81;
      for (int g = 0; g < 4; g++) begin
         e = (g % 2 == 0) ? 8'h01 : 8'h80;
         tick();
         total++; if (bif.ack !== e) $display("FAIL alt_grant%0d: got %h want %h", g, bif.ack, e); else passed++;
         tick();
         tick();
         total++; if (bif.ack !== e) $display("FAIL alt_hold%0d: got %h want %h", g, bif.ack, e); else passed++;
         bif.req = 8'h81 & ~e;
         tick();
         total++; if (bif.ack !== 8'h00) $display("FAIL alt_idle%0d: got %h want 00", g, bif.ack); else passed++;
         bif.req = 8'h81;
      end
      bif.req = 8'h00;
      tick();
   endtask

   task automatic test_three_way();
      logic [7:0] e;
      int         id;
      for (int g = 0; g < 4; g++) begin
         case (g)
            0: begin e = 8'h01; id = 0; end
            1: begin e = 8'h04; id = 2; end
            2: begin e = 8'h80; id = 7; end
            default: begin e = 8'h01; id = 0; end
         endcase
         bif.req = 8'h85;
         tick();
         total++; if (bif.ack !== e) $display("FAIL rr_grant%0d: got %h want %h", g, bif.ack, e); else passed++;
         total++; if (bif.owner_id !== 3'(id)) $display("FAIL rr_owner%0d: got %0d want %0d", g, bif.owner_id, id); else passed++;
         total++; if (bif.bus_out !== exp_data(id)) $display("FAIL rr_bus%0d: got %h want %h", g, bif.bus_out, exp_data(id)); else passed++;
         bif.req = 8'h85 & ~e;
         tick();
         total++; if (bif.ack !== 8'h00) $display("FAIL rr_idle%0d: got %h want 00", g, bif.ack); else passed++;
      end
      bif.req = 8'h00;
      tick();
   endtask

   task automatic test_watchdog();
      bif.req = 8'h14;
      tick();
      total++; if (bif.ack !== 8'h04) $display("FAIL wd_grant: got %h want 04", bif.ack); else passed++;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++; if (bif.ack !== 8'h04 || bif.timeout_err !== 1'b0)
            $display("FAIL wd_hold%0d: got ack %h tmo %b want ack 04 tmo 0", c, bif.ack, bif.timeout_err);
         else passed++;
      end
      tick();
      total++; if (bif.ack !== 8'h00) $display("FAIL wd_revoke_ack: got %h want 00", bif.ack); else passed++;
      total++; if (bif.timeout_err !== 1'b1) $display("FAIL wd_revoke_tmo: got %b want 1", bif.timeout_err); else passed++;
      total++; if (bif.busy !== 1'b0) $display("FAIL wd_revoke_busy: got %b want 0", bif.busy); else passed++;
      tick();
      total++; if (bif.ack !== 8'h10) $display("FAIL wd_next_ack: got %h want 10", bif.ack); else passed++;
      total++; if (bif.owner_id !== 3'd4) $display("FAIL wd_next_owner: got %0d want 4", bif.owner_id); else passed++;
      total++; if (bif.timeout_err !== 1'b0) $display("FAIL wd_tmo_pulse: got %b want 0", bif.timeout_err); else passed++;
      bif.req = 8'h04;
      tick();
      total++; if (bif.ack !== 8'h00) $display("FAIL wd_rel4: got %h want 00", bif.ack); else passed++;
      tick();
      total++; if (bif.ack !== 8'h00) $display("FAIL wd_masked: got %h want 00", bif.ack); else passed++;
      bif.req = 8'h00;
      tick();
      bif.req = 8'h04;
      tick();
      total++; if (bif.ack !== 8'h04) $display("FAIL wd_regrant: got %h want 04", bif.ack); else passed++;
      bif.req = 8'h00;
      tick();
      total++; if (bif.ack !== 8'h00) $display("FAIL wd_final_rel: got %h want 00", bif.ack); else passed++;
   endtask

   task automatic test_release_at_expiry();
      bif.req = 8'h04;
      tick();
      total++; if (bif.ack !== 8'h04) $display("FAIL exp_grant: got %h want 04", bif.ack); else passed++;
      tick();
      tick();
      tick();
      total++; if (bif.ack !== 8'h04) $display("FAIL exp_hold: got %h want 04", bif.ack); else passed++;
      bif.req = 8'h00;
      tick();
      total++; if (bif.ack !== 8'h00) $display("FAIL exp_rel_ack: got %h want 00", bif.ack); else passed++;
      total++; if (bif.timeout_err !== 1'b0) $display("FAIL exp_rel_tmo: got %b want 0", bif.timeout_err); else passed++;
      bif.req = 8'h04;
      tick();
      total++; if (bif.ack !== 8'h04) $display("FAIL exp_unmasked: got %h want 04", bif.ack); else passed++;
      bif.req = 8'h00;
      tick();
      total++; if (bif.timeout_err !== 1'b0) $display("FAIL exp_after_tmo: got %b want 0", bif.timeout_err); else passed++;
   endtask

   task automatic test_reset_mid_grant();
      bif.req = 8'h80;
      tick();
      total++; if (bif.ack !== 8'h80) $display("FAIL rst_pre_ack: got %h want 80", bif.ack); else passed++;
      tick();
      reset   = 1'b1;
      bif.req = 8'hFF;
      tick();
      total++; if (bif.ack !== 8'h00) $display("FAIL rst_mid_ack: got %h want 00", bif.ack); else passed++;
      total++; if (bif.owner_id !== 3'd0) $display("FAIL rst_mid_owner: got %0d want 0", bif.owner_id); else passed++;
      total++; if (bif.busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", bif.busy); else passed++;
      reset = 1'b0;
      tick();
      total++; if (bif.ack !== 8'h01) $display("FAIL rst_first_ack: got %h want 01", bif.ack); else passed++;
      total++; if (bif.owner_id !== 3'd0) $display("FAIL rst_first_owner: got %0d want 0", bif.owner_id); else passed++;
      bif.req = 8'h00;
      tick();
      total++; if (bif.ack !== 8'h00) $display("FAIL rst_final_rel: got %h want 00", bif.ack); else passed++;
   endtask

   initial begin
      for (int i = 0; i < int'(N); i++) begin
         bif.bus_in[i*DW +: DW]  = exp_data(i);
         bif.ctrl_in[i*CW +: CW] = exp_ctrl(i);
      end
      test_reset();
      test_single_cpu();
      test_alternate();
      test_three_way();
      test_watchdog();
      test_release_at_expiry();
      test_reset_mid_grant();
      run_checks = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/bus_round_robin_arbiter.md
Name: bus_round_robin_arbiter

Overview:
Shares the system data/control bus among up to NUM_DEVICES masters: the CPU, the SRAM controller, and future VGA, PS2 and audio-copper devices. It replaces fixed-priority bus selection with registered round-robin grants, a hold-time watchdog, and a muxed bus drive. Bus IDs match the system assignment: 0 RAM, 1 ROM, 2 VGA, 3 PS2, 4 ACP, 7 CPU.

Parameters:
NUM_DEVICES, 8, number of requester slots; must be a power of two, max 8.
ID_WIDTH, 3, log2(NUM_DEVICES).
D_WIDTH, 32, bus data width.
C_WIDTH, 8, bus control width.
MAX_HOLD, 255, maximum cycles one owner may hold the bus; 0 disables the watchdog.

Ports:
clk50MHz  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
req  input  NUM_DEVICES  per-device bus request; held high for the whole transaction.
ack  output  NUM_DEVICES  one-hot-or-zero grant; registered.
bus_in  input  NUM_DEVICES*D_WIDTH  flattened data; slice i = [i*D_WIDTH +: D_WIDTH].
ctrl_in  input  NUM_DEVICES*C_WIDTH  flattened control; slice i = [i*C_WIDTH +: C_WIDTH].
bus_out  output  D_WIDTH  owner's data; 0 when idle.
ctrl_out  output  C_WIDTH  owner's control; 0 when idle.
busy  output  1  high while any ack is high.
owner_id  output  ID_WIDTH  index of current owner; 0 when not busy.
timeout_err  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset: ack=0, busy=0, owner_id=0, timeout_err=0, hold counter=0, mask=0, last_owner=NUM_DEVICES-1 so device 0 has first priority. State=IDLE. Reset mid-grant drops ack on that edge.
- Two states:
  - IDLE to OWNED: at an edge where (req & ~mask) != 0.
  - OWNED to IDLE: on release or on watchdog revoke.
- IDLE:
  - Winner = first set bit of (req & ~mask), scanning upward from last_owner+1 modulo NUM_DEVICES.
  - At the same edge: ack[winner]=1, owner_id=winner, last_owner=winner, counter=0.
  - Grant latency: 1 cycle from req first sampled high.
- OWNED:
  - bus_out and ctrl_out are combinational muxes of the owner's slices.
  - Counter increments each edge and saturates at MAX_HOLD.
  - Release: req[owner] sampled low -> ack=0 and state=IDLE at that edge. No new grant is issued on the same edge, which guarantees at least one idle turnaround cycle between owners.
  - Requests from other devices while OWNED are ignored (no preemption). They are arbitrated on the next IDLE edge.
- Watchdog (MAX_HOLD != 0): if counter == MAX_HOLD-1 at an edge while req[owner] is still high:
  - ack=0, timeout_err=1 for one cycle, mask[owner]=1, state=IDLE.
  - A release on that same edge takes priority: normal IDLE, no error.
- Mask: mask[i] clears at any edge where req[i] is sampled low. A revoked device therefore cannot be regranted until it drops and re-raises req.
- A req bit that drops before it is granted is simply not considered; requests are not latched.
- Outputs never carry X: bus_out and ctrl_out are forced to 0 whenever busy=0.
- Only one ack bit may be high at a time (assertion in the bench).

Test Plan:
- Reset, then req=8'h80 (CPU) -> ack=8'h80 one cycle later; busy=1, owner_id=7, bus_out = CPU slice. Drop req -> ack=0 next edge, bus_out=0.
- req=8'h81 held, each owner drops req after 3 cycles and re-raises one cycle later -> grants alternate 0,7,0,7 with one idle cycle between grants.
- req=8'h85 all held continuously with release after each grant -> grant order 0,2,7,0; never 0,0.
- MAX_HOLD=4, device 2 holds req indefinitely -> ack[2] drops after 4 owned cycles, timeout_err pulses once, req[4] pending is granted next. Device 2 is not regranted until req[2] toggles low then high.
- Assert reset while device 7 is owned -> ack=0, owner_id=0, busy=0 at that edge. With req=8'hFF after reset -> device 0 is granted first.
- Release and watchdog expiry on the same edge -> timeout_err stays 0 and mask is unchanged.
